// File: rtl/sdram_mem_tester.sv
// Burst-oriented SDRAM self-test: writes a pattern over a page range, reads it back,
// counts mismatches and captures the first failing word.
module sdram_mem_tester #(
    parameter int          SDRAM_ROW_WIDTH_BIT  = 12,
    parameter int          SDRAM_COL_WIDTH_BIT  = 8,
    parameter int          SDRAM_BANK_WIDTH_BIT = 2,
    parameter int          SDRAM_DATA_WIDTH_BIT = 16,
    parameter int          ERR_CNT_WIDTH        = 16,
    parameter int unsigned TIMEOUT              = 16'd4096,
    parameter logic [15:0] LFSR_SEED            = 16'hACE1
) (
    input  logic                                            i_clk,
    input  logic                                            i_rst_n,
    input  logic                                            i_start,
    input  logic                                            i_abort,
    input  logic [1:0]                                      i_mode,
    input  logic                                            i_loop,
    input  logic [SDRAM_BANK_WIDTH_BIT+SDRAM_ROW_WIDTH_BIT-1:0] i_page_first,
    input  logic [SDRAM_BANK_WIDTH_BIT+SDRAM_ROW_WIDTH_BIT-1:0] i_page_last,
    input  logic                                            i_ram_ready,
    output logic [SDRAM_BANK_WIDTH_BIT+SDRAM_ROW_WIDTH_BIT+SDRAM_COL_WIDTH_BIT-1:0] o_ram_addr,
    output logic [SDRAM_COL_WIDTH_BIT:0]                    o_ram_len,
    output logic                                            o_ram_write_req,
    output logic                                            o_ram_read_req,
    input  logic                                            i_ram_write_valid,
    input  logic                                            i_ram_read_valid,
    output logic [SDRAM_DATA_WIDTH_BIT-1:0]                 o_ram_wdata,
    input  logic [SDRAM_DATA_WIDTH_BIT-1:0]                 i_ram_rdata,
    output logic                                            o_busy,
    output logic                                            o_done,
    output logic                                            o_pass,
    output logic                                            o_timeout,
    output logic [ERR_CNT_WIDTH-1:0]                        o_err_cnt,
    output logic [SDRAM_BANK_WIDTH_BIT+SDRAM_ROW_WIDTH_BIT+SDRAM_COL_WIDTH_BIT-1:0] o_err_addr,
    output logic [SDRAM_DATA_WIDTH_BIT-1:0]                 o_err_exp,
    output logic [SDRAM_DATA_WIDTH_BIT-1:0]                 o_err_got,
    output logic [2:0]                                      o_pass_num,
    output logic [15:0]                                     o_loop_cnt
);
    localparam int COL = SDRAM_COL_WIDTH_BIT;
    localparam int PA  = SDRAM_BANK_WIDTH_BIT + SDRAM_ROW_WIDTH_BIT;
    localparam int A   = PA + COL;
    localparam int DW  = SDRAM_DATA_WIDTH_BIT;
    localparam logic [COL:0]  BURST_LEN = {1'b1, {COL{1'b0}}};
    localparam logic [31:0]   TMO_LAST  = 32'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_RDY, WR_REQ, WR_BURST, WR_NEXT,
        RD_REQ, RD_BURST, RD_NEXT, PASS_NEXT, DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [1:0]               mode_q;
    logic [PA-1:0]            first_q, last_q, page_q;
    logic [COL-1:0]           word_q;
    logic [2:0]               pass_q;
    logic [15:0]              loop_q;
    logic [15:0]              lfsr_q;
    logic [31:0]              tmo_q;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
    logic [A-1:0]             err_addr_q;
    logic [DW-1:0]            err_exp_q, err_got_q;
    logic                     timeout_q, abort_q;

    logic [A-1:0]  word_addr;
    logic [DW-1:0] exp_word;
    logic [2:0]    last_pass_num;
    logic          wr_vld, rd_vld, beat, in_req, tmo_hit, last_word, last_pass, abort_any, busy;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    assign word_addr = {page_q, word_q};

    always_comb begin
        exp_word = '0;
        case (mode_q)
            2'd1: exp_word = pass_q[0] ? ~DW'(word_addr) : DW'(word_addr);
            2'd2: exp_word = DW'(lfsr_q);
            default: begin
                case (pass_q[1:0])
                    2'd0:    exp_word = '0;
                    2'd1:    exp_word = '1;
                    2'd2:    exp_word = DW'({(DW/2+1){2'b10}});
                    default: exp_word = DW'({(DW/2+1){2'b01}});
                endcase
            end
        endcase
    end

    always_comb begin
        case (mode_q)
            2'd1:    last_pass_num = 3'd1;
            2'd2:    last_pass_num = 3'd0;
            default: last_pass_num = 3'd3;
        endcase
    end

    assign wr_vld    = i_ram_write_valid && (state_q == WR_REQ || state_q == WR_BURST);
    assign rd_vld    = i_ram_read_valid  && (state_q == RD_REQ || state_q == RD_BURST);
    assign beat      = wr_vld || rd_vld;
    assign in_req    = (state_q == WR_REQ) || (state_q == RD_REQ);
    assign tmo_hit   = in_req && !beat && (tmo_q == TMO_LAST);
    assign last_word = &word_q;
    assign last_pass = (pass_q == last_pass_num);
    assign abort_any = abort_q || i_abort;
    assign busy      = (state_q != IDLE) && (state_q != DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (i_start) state_d = WAIT_RDY;
            WAIT_RDY:   if (i_ram_ready) state_d = WR_REQ;
            WR_REQ: begin
                if (wr_vld)       state_d = last_word ? WR_NEXT : WR_BURST;
                else if (tmo_hit) state_d = DONE;
            end
            WR_BURST:   if (wr_vld && last_word) state_d = WR_NEXT;
            WR_NEXT: begin
                if (abort_any)            state_d = DONE;
                else if (page_q < last_q) state_d = WR_REQ;
                else                      state_d = RD_REQ;
            end
            RD_REQ: begin
                if (rd_vld)       state_d = last_word ? RD_NEXT : RD_BURST;
                else if (tmo_hit) state_d = DONE;
            end
            RD_BURST:   if (rd_vld && last_word) state_d = RD_NEXT;
            RD_NEXT: begin
                if (abort_any)            state_d = DONE;
                else if (page_q < last_q) state_d = RD_REQ;
                else                      state_d = PASS_NEXT;
            end
            PASS_NEXT: begin
                if (abort_any)                  state_d = DONE;
                else if (!last_pass || i_loop)  state_d = WR_REQ;
                else                            state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mode_q     <= '0;
            first_q    <= '0;
            last_q     <= '0;
            page_q     <= '0;
            word_q     <= '0;
            pass_q     <= '0;
            loop_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            tmo_q      <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
            timeout_q  <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            if (beat) begin
                word_q <= word_q + 1'b1;
                lfsr_q <= lfsr_step(lfsr_q);
            end
            tmo_q <= (in_req && !beat) ? tmo_q + 32'd1 : 32'd0;
            if (tmo_hit) timeout_q <= 1'b1;
            if (busy && i_abort) abort_q <= 1'b1;

            if (rd_vld && (i_ram_rdata != exp_word)) begin
                if (err_cnt_q == '0) begin
                    err_addr_q <= word_addr;
                    err_exp_q  <= exp_word;
                    err_got_q  <= i_ram_rdata;
                end
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
            end

            case (state_q)
                IDLE, DONE: begin
                    abort_q <= 1'b0;
                    if (i_start) begin
                        mode_q     <= i_mode;
                        first_q    <= i_page_first;
                        // an inverted range collapses to the first page alone
                        last_q     <= (i_page_first > i_page_last) ? i_page_first : i_page_last;
                        page_q     <= i_page_first;
                        word_q     <= '0;
                        pass_q     <= '0;
                        loop_q     <= '0;
                        lfsr_q     <= LFSR_SEED;
                        err_cnt_q  <= '0;
                        err_addr_q <= '0;
                        err_exp_q  <= '0;
                        err_got_q  <= '0;
                        timeout_q  <= 1'b0;
                    end
                end
                WAIT_RDY: begin
                    page_q <= first_q;
                    word_q <= '0;
                    lfsr_q <= LFSR_SEED;
                end
                WR_NEXT, RD_NEXT: begin
                    word_q <= '0;
                    if (page_q < last_q) begin
                        page_q <= page_q + 1'b1;
                    end else begin
                        page_q <= first_q;
                        lfsr_q <= LFSR_SEED;
                    end
                end
                PASS_NEXT: begin
                    page_q <= first_q;
                    word_q <= '0;
                    lfsr_q <= LFSR_SEED;
                    if (!abort_any) begin
                        if (!last_pass) begin
                            pass_q <= pass_q + 1'b1;
                        end else if (i_loop) begin
                            pass_q <= '0;
                            loop_q <= loop_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ram_addr      = {page_q, {COL{1'b0}}};
    assign o_ram_len       = BURST_LEN;
    assign o_ram_write_req = (state_q == WR_REQ);
    assign o_ram_read_req  = (state_q == RD_REQ);
    assign o_ram_wdata     = exp_word;
    assign o_busy          = busy;
    assign o_done          = (state_q == DONE);
    assign o_pass          = (state_q == DONE) && (err_cnt_q == '0) && !timeout_q;
    assign o_timeout       = timeout_q;
    assign o_err_cnt       = err_cnt_q;
    assign o_err_addr      = err_addr_q;
    assign o_err_exp       = err_exp_q;
    assign o_err_got       = err_got_q;
    assign o_pass_num      = pass_q;
    assign o_loop_cnt      = loop_q;
endmodule

// File: tb/tb_sdram_mem_tester.sv
// Directed bench for sdram_mem_tester with a behavioural burst memory controller.
module tb_sdram_mem_tester;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0, i_abort = 1'b0, i_loop = 1'b0, i_ram_ready = 1'b0;
    logic [1:0]  i_mode = '0;
    logic [13:0] i_page_first = '0, i_page_last = '0;
    logic [21:0] o_ram_addr;
    logic [8:0]  o_ram_len;
    logic        o_ram_write_req, o_ram_read_req;
    logic        i_ram_write_valid, i_ram_read_valid;
    logic [15:0] o_ram_wdata, i_ram_rdata;
    logic        o_busy, o_done, o_pass, o_timeout;
    logic [15:0] o_err_cnt;
    logic [21:0] o_err_addr;
    logic [15:0] o_err_exp, o_err_got;
    logic [2:0]  o_pass_num;
    logic [15:0] o_loop_cnt;

    int total = 0, bad = 0;

    sdram_mem_tester dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_mode(i_mode), .i_loop(i_loop), .i_page_first(i_page_first),
        .i_page_last(i_page_last), .i_ram_ready(i_ram_ready),
        .o_ram_addr(o_ram_addr), .o_ram_len(o_ram_len),
        .o_ram_write_req(o_ram_write_req), .o_ram_read_req(o_ram_read_req),
        .i_ram_write_valid(i_ram_write_valid), .i_ram_read_valid(i_ram_read_valid),
        .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata),
        .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass), .o_timeout(o_timeout),
        .o_err_cnt(o_err_cnt), .o_err_addr(o_err_addr), .o_err_exp(o_err_exp),
        .o_err_got(o_err_got), .o_pass_num(o_pass_num), .o_loop_cnt(o_loop_cnt)
    );

    always #5 i_clk = ~i_clk;

    // memory/controller model: fault 0 ideal, 1 bit3 stuck-at-1 at 0x105, 2 reads return 0, 3 never valid
    logic [15:0] mem [int];
    int   fault = 0, bursts = 0, cnt = 0, dly = 0, req_cycles = 0, overlap = 0;
    bit   mbusy = 0, mwr = 0, gapped = 0;
    int   maddr = 0;

    initial begin
        i_ram_write_valid = 1'b0;
        i_ram_read_valid  = 1'b0;
        i_ram_rdata       = '0;
        forever begin
            @(negedge i_clk);
            i_ram_write_valid = 1'b0;
            i_ram_read_valid  = 1'b0;
            if (!i_rst_n) begin
                mbusy = 0;
            end else begin
                if (o_ram_write_req || o_ram_read_req) req_cycles++;
                if (o_ram_write_req && o_ram_read_req) overlap++;
                if (!mbusy && (o_ram_write_req || o_ram_read_req) && fault != 3) begin
                    mbusy = 1; mwr = o_ram_write_req; maddr = int'(o_ram_addr);
                    cnt = 0; dly = 2; gapped = 0; bursts++;
                end else if (mbusy) begin
                    if (dly > 0) dly--;
                    else if (cnt == 100 && !gapped) gapped = 1;
                    else begin
                        if (mwr) begin
                            mem[maddr + cnt] = o_ram_wdata;
                            i_ram_write_valid = 1'b1;
                        end else begin
                            i_ram_rdata = mem[maddr + cnt];
                            if (fault == 1 && maddr + cnt == 32'h105) i_ram_rdata = i_ram_rdata | 16'h0008;
                            if (fault == 2) i_ram_rdata = '0;
                            i_ram_read_valid = 1'b1;
                        end
                        cnt++;
                        if (cnt == 256) mbusy = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [1:0] md, input logic [13:0] pf, input logic [13:0] pl, input logic lp);
        @(negedge i_clk);
        #2;
        i_mode = md; i_page_first = pf; i_page_last = pl; i_loop = lp;
        bursts = 0; i_start = 1'b1;
        @(negedge i_clk);
        #2;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (o_done !== 1'b1 && n < budget) begin
            @(negedge i_clk);
            n++;
        end
    endtask

    initial begin
        int n;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_reqs", 32'({o_ram_write_req, o_ram_read_req}), 32'd0);
        chk("rst_len", 32'(o_ram_len), 32'd256);
        chk("rst_err", 32'(o_err_cnt), 32'd0);
        chk("rst_wdata", 32'(o_ram_wdata), 32'd0);
        i_rst_n = 1'b1;

        // mode 0, pages 0..3, ready held low first
        run(2'd0, 14'd0, 14'd3, 1'b0);
        repeat (4) @(negedge i_clk);
        chk("wait_rdy_busy", 32'(o_busy), 32'd1);
        chk("wait_rdy_noreq", 32'(o_ram_write_req), 32'd0);
        i_ram_ready = 1'b1;
        wait_done(20000);
        chk("m0_done", 32'(o_done), 32'd1);
        chk("m0_pass", 32'(o_pass), 32'd1);
        chk("m0_err", 32'(o_err_cnt), 32'd0);
        chk("m0_bursts", 32'(bursts), 32'd32);
        chk("m0_pass_num", 32'(o_pass_num), 32'd3);
        chk("m0_busy", 32'(o_busy), 32'd0);
        chk("m0_mem", 32'(mem[32'h3FF]), 32'h5555);

        // stuck bit at word 0x105: fails in pass 0 and pass 3
        fault = 1;
        run(2'd0, 14'd0, 14'd1, 1'b0);
        wait_done(10000);
        chk("stuck_pass", 32'(o_pass), 32'd0);
        chk("stuck_cnt", 32'(o_err_cnt), 32'd2);
        chk("stuck_addr", 32'(o_err_addr), 32'h105);
        chk("stuck_exp", 32'(o_err_exp), 32'h0000);
        chk("stuck_got", 32'(o_err_got), 32'h0008);

        // LFSR echo with an inverted range -> single page 5
        fault = 0;
        run(2'd2, 14'd5, 14'd2, 1'b0);
        wait_done(5000);
        chk("lfsr_pass", 32'(o_pass), 32'd1);
        chk("lfsr_bursts", 32'(bursts), 32'd2);
        chk("lfsr_w0", 32'(mem[32'h500]), 32'hACE1);
        chk("lfsr_w1", 32'(mem[32'h501]), 32'hE270);

        // LFSR against a memory returning zero
        fault = 2;
        run(2'd2, 14'd3, 14'd3, 1'b0);
        wait_done(5000);
        chk("zero_cnt", 32'(o_err_cnt), 32'd256);
        chk("zero_addr", 32'(o_err_addr), 32'h300);
        chk("zero_exp", 32'(o_err_exp), 32'hACE1);
        chk("zero_got", 32'(o_err_got), 32'h0000);
        chk("zero_pass", 32'(o_pass), 32'd0);

        // address / inverse address
        fault = 0;
        run(2'd1, 14'd2, 14'd2, 1'b0);
        wait_done(5000);
        chk("addr_pass", 32'(o_pass), 32'd1);
        chk("addr_mem", 32'(mem[32'h207]), 32'hFDF8);

        // controller never answers
        fault = 3;
        req_cycles = 0;
        run(2'd0, 14'd0, 14'd0, 1'b0);
        wait_done(6000);
        chk("tmo_done", 32'(o_done), 32'd1);
        chk("tmo_flag", 32'(o_timeout), 32'd1);
        chk("tmo_req", 32'(o_ram_write_req), 32'd0);
        chk("tmo_pass", 32'(o_pass), 32'd0);
        chk("tmo_cycles", 32'(req_cycles), 32'd4096);
        fault = 0;

        // looping, abort raised mid-burst during loop 2
        run(2'd1, 14'd0, 14'd0, 1'b1);
        n = 0;
        while (!(o_loop_cnt == 16'd2 && i_ram_write_valid && cnt > 50) && n < 20000) begin
            @(negedge i_clk);
            n++;
        end
        #2 i_abort = 1'b1;
        @(negedge i_clk);
        #2 i_abort = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd1);
        wait_done(2000);
        chk("abort_done", 32'(o_done), 32'd1);
        chk("abort_loops", 32'(o_loop_cnt), 32'd2);
        chk("abort_burst_len", 32'(cnt), 32'd256);
        chk("abort_pass", 32'(o_pass), 32'd1);

        // reset in the middle of a read burst
        run(2'd0, 14'd0, 14'd1, 1'b0);
        n = 0;
        while (!(i_ram_read_valid && cnt > 30) && n < 5000) begin
            @(negedge i_clk);
            n++;
        end
        #2 i_rst_n = 1'b0;
        #1;
        chk("mid_rst_reqs", 32'({o_ram_write_req, o_ram_read_req}), 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_addr", 32'(o_ram_addr), 32'd0);
        chk("mid_rst_pass_num", 32'(o_pass_num), 32'd0);
        chk("mid_rst_len", 32'(o_ram_len), 32'd256);
        repeat (2) @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        run(2'd0, 14'd0, 14'd0, 1'b0);
        wait_done(5000);
        chk("post_rst_pass", 32'(o_pass), 32'd1);
        chk("post_rst_bursts", 32'(bursts), 32'd8);
        chk("no_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdram_mem_tester.md
SDRAM_MEM_TESTER -- requirements
Module: sdram_mem_tester

Interface
REQ-001 SHALL have parameters: SDRAM_ROW_WIDTH_BIT, default 12, row address bits; SDRAM_COL_WIDTH_BIT, default 8, column bits; SDRAM_BANK_WIDTH_BIT, default 2, bank bits; SDRAM_DATA_WIDTH_BIT, default 16, data bits; ERR_CNT_WIDTH, default 16, error counter bits; TIMEOUT, default 16'd4096, max cycles from request to first valid; LFSR_SEED, default 16'hACE1, nonzero seed.
REQ-002 SHALL use PA = BANK+ROW bits (page address) and A = PA+COL bits (word address).
REQ-003 SHALL have ports (name, direction, width, meaning), clock and reset first:
  i_clk  in  1  single clock, all logic on rising edge
  i_rst_n  in  1  asynchronous active-low reset
  i_start  in  1  one-cycle start pulse, accepted only in IDLE
  i_abort  in  1  stop after current burst
  i_mode  in  2  0 fixed patterns, 1 address/inverse-address, 2 LFSR, 3 same as 0
  i_loop  in  1  repeat test until abort
  i_page_first / i_page_last  in  PA  inclusive page range
  i_ram_ready  in  1  controller initialised
  o_ram_addr  out  A  burst start address, column bits 0
  o_ram_len  out  COL+1  burst length, always 2**COL
  o_ram_write_req / o_ram_read_req  out  1  burst requests
  i_ram_write_valid / i_ram_read_valid  in  1  per-word strobes
  o_ram_wdata  out  DATA  write word; i_ram_rdata  in  DATA  read word
  o_busy, o_done, o_pass, o_timeout  out  1  status
  o_err_cnt  out  ERR_CNT_WIDTH  mismatch count
  o_err_addr  out  A; o_err_exp, o_err_got  out  DATA  first-mismatch capture
  o_pass_num  out  3  current pattern pass; o_loop_cnt  out  16  completed loops

Function
REQ-004 SHALL implement states IDLE, WAIT_RDY, WR_REQ, WR_BURST, WR_NEXT, RD_REQ, RD_BURST, RD_NEXT, PASS_NEXT, DONE.
REQ-005 IDLE: i_start -> WAIT_RDY; clear err_cnt, capture regs, o_timeout, o_done, pass_num, loop_cnt; latch mode and page range.
REQ-006 WAIT_RDY -> WR_REQ when i_ram_ready=1; page = page_first.
REQ-007 WR_REQ: o_ram_write_req=1, o_ram_addr={page, COL zeros}, o_ram_len=2**COL; req SHALL drop in the cycle after the first i_ram_write_valid; enter WR_BURST.
REQ-008 Each cycle with i_ram_write_valid=1, the controller samples o_ram_wdata; word index and pattern generator SHALL advance in the following cycle; burst ends after 2**COL strobes.
REQ-009 WR_NEXT: page<page_last -> page+1, WR_REQ; else page=page_first, restart generator, RD_REQ.
REQ-010 RD_REQ/RD_BURST/RD_NEXT mirror write; each i_ram_read_valid compares i_ram_rdata to expected word for the same index.
REQ-011 Mismatch: err_cnt += 1, saturating at all-ones; when err_cnt was 0, capture address, expected, received.
REQ-012 Patterns: mode 0 passes 0..3 = 0x0000, 0xFFFF, 0xAAAA, 0x5555 (replicated to DATA width); mode 1 pass 0 = low DATA bits of word address, pass 1 = its inverse; mode 2 single pass, Galois LFSR x^16+x^14+x^13+x^11+1 reseeded with LFSR_SEED at start of each phase, stepped per word.
REQ-013 PASS_NEXT: more passes -> pass_num+1, WR_REQ at page_first; else i_loop=1 and no abort -> loop_cnt+1 (wrapping), pass_num=0, WR_REQ; else DONE.
REQ-014 i_abort (sticky until DONE) SHALL never break a burst; takes effect at next WR_NEXT/RD_NEXT -> DONE.
REQ-015 Timeout: req asserted TIMEOUT cycles without valid -> drop req, o_timeout=1, DONE.
REQ-016 DONE: o_done=1, o_pass=(err_cnt==0 && !o_timeout); i_start restarts as in IDLE.
REQ-017 o_busy=1 in all states except IDLE and DONE.
REQ-018 page_first>page_last SHALL be treated as a single page, page_first.
REQ-019 Write and read requests SHALL never be asserted together.

Reset
REQ-020 i_rst_n=0 SHALL asynchronously force IDLE; all outputs 0; o_ram_len=2**COL; LFSR=LFSR_SEED.
REQ-021 Reset mid-burst SHALL drop requests immediately; no state retained.

Verification
REQ-022 Mode 0, pages 0..3, ideal memory model -> 4 passes, o_done=1, o_pass=1, o_err_cnt=0, 32 bursts of 256 words.
REQ-023 Model forces bit 3 stuck-at-1 at word 0x00105 -> first error in pass 0: o_err_addr=0x00105, o_err_exp=0x0000, o_err_got=0x0008; o_pass=0.
REQ-024 Mode 2, single page, model echoes stored data -> o_pass=1; model returning 0 -> o_err_cnt=256.
REQ-025 Controller never asserts write_valid -> o_timeout=1 after 4096 cycles, requests low, o_done=1.
REQ-026 i_loop=1, i_abort raised mid-burst in loop 2 -> burst completes, DONE, o_loop_cnt=2.
REQ-027 i_rst_n low during RD_BURST -> next cycle all outputs 0, state IDLE; new i_start runs cleanly.
